// File: rtl/cog_vidx_pkg.sv
// cog_vidx_pkg: shared encodings, vid field positions, broadcast level table
// and small helper functions for the cog_vidx video generator.
package cog_vidx_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_DISC = 2'b01,
    MODE_BB   = 2'b10,
    MODE_BC   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    BPP_1  = 2'b00,
    BPP_2  = 2'b01,
    BPP_4  = 2'b10,
    BPP_4X = 2'b11
  } bpp_e;

  // vid register field positions
  localparam int VID_UR_CLR_BIT    = 31;
  localparam int VID_MODE_LSB      = 29;
  localparam int VID_BPP_LSB       = 27;
  localparam int VID_BB_CHROMA_BIT = 26;
  localparam int VID_BC_CHROMA_BIT = 25;
  localparam int VID_AURAL_LSB     = 22;
  localparam int VID_GROUP_LSB     = 8;
  localparam int VID_MASK_LSB      = 0;

  // scale register field positions
  localparam int SCL_CPP_LSB = 12;
  localparam int SCL_CPS_LSB = 0;

  // Broadcast level table, entry i at [3*i +: 3], index {carrier, composite[2:0]}.
  // Carrier low follows the composite level, carrier high mirrors it.
  localparam logic [47:0] BC_LEVEL_TABLE = {
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
    3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0
  };

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Chroma phase add plus luma modulation: the hue nibble offsets the running
  // phase; when chroma is on the luma level is nudged up/down with the carrier.
  function automatic logic [3:0] chroma_mod(input logic [7:0] disc,
                                            input logic [3:0] phase,
                                            input logic       chroma_en);
    logic [3:0] sum;
    logic [2:0] luma;
    logic       chroma;
    chroma = chroma_en & disc[3];
    sum    = phase + disc[7:4];
    luma   = disc[2:0];
    if (chroma) begin
      if (sum[3]) luma = (luma == 3'd7) ? luma : luma + 3'd1;
      else        luma = (luma == 3'd0) ? luma : luma - 3'd1;
    end
    return {chroma & sum[3], luma};
  endfunction

endpackage

// File: rtl/cog_vidx_fifo.sv
// cog_vidx_fifo: small synchronous FIFO for pixel/palette sets, with flush.
// A push at full is refused even when a pop happens in the same cycle.
module cog_vidx_fifo
  import cog_vidx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 160
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [clog2(DEPTH):0]    count,
  output logic                     empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign push_ok = push && (count_reg < (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];

  // storage write; contents need no reset, the pointers qualify them
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/cog_vidx.sv
// cog_vidx: parametrised cog video generator on a single video clock.
// Sets (pixels + palette) arrive through a valid/ready FIFO; a pixel/set
// counter pair paces the shifter; the palette-looked-up byte is masked and
// placed on one 8-bit group of pin_out.
// Optional composite output (phase, baseband, broadcast) is compiled in
// with the macro COG_VIDX_COMPOSITE_EN; without it modes 10/11 act as 01.
module cog_vidx
  import cog_vidx_pkg::*;
#(
  parameter int PIN_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ENTRY_W    = 8
) (
  input  logic                   clk_vid,
  input  logic                   res,
  input  logic                   cfg_we,
  input  logic [31:0]            cfg_data,
  input  logic                   scl_we,
  input  logic [19:0]            scl_data,
  input  logic                   set_valid,
  output logic                   set_ready,
  input  logic [31:0]            pixel,
  input  logic [16*ENTRY_W-1:0]  color,
  input  logic [7:0]             aural,
  input  logic                   carrier,
  output logic                   underrun,
  output logic                   busy,
  output logic [PIN_W-1:0]       pin_out
);

  localparam int SET_WIDTH = 32 + 16*ENTRY_W;
  localparam int CW        = clog2(FIFO_DEPTH) + 1;
  localparam int GROUPS    = PIN_W / 8;
  localparam int GW        = clog2(GROUPS);
  localparam int EB        = (ENTRY_W < 8) ? ENTRY_W : 8;

  logic [31:0]            vid_reg;
  logic [19:0]            scl_reg;
  logic [7:0]             cnt_reg, cnt_next;
  logic [11:0]            set_reg, set_next;
  logic [31:0]            pixels_reg, pixels_next, pixels_shifted;
  logic [16*ENTRY_W-1:0]  palette_reg, palette_next;
  logic                   underrun_reg, underrun_next;
  logic                   active_reg, active_next;
  logic [7:0]             discrete_reg;
  logic [ENTRY_W-1:0]     entry_sel;
  logic [7:0]             entry_byte;
  logic [7:0]             out_byte;
  logic [3:0]             pix_idx;
  logic [4:0]             grp;
  mode_e                  mode;
  bpp_e                   bpp;

  logic                   fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [SET_WIDTH-1:0]   fifo_dout;
  logic                   unused_bits;

  assign mode = mode_e'(vid_reg[VID_MODE_LSB +: 2]);
  assign bpp  = bpp_e'(vid_reg[VID_BPP_LSB +: 2]);

  assign set_ready  = (mode != MODE_OFF) && (fifo_count < CW'(FIFO_DEPTH));
  assign fifo_push  = set_valid && set_ready;
  assign fifo_flush = (mode == MODE_OFF);
  assign underrun   = underrun_reg;
  assign busy       = !fifo_empty || active_reg;

  cog_vidx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SET_WIDTH)
  ) u_fifo (
    .clk   (clk_vid),
    .rst   (res),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({color, pixel}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // current pixel index and the pixel word after one pixel's worth of shift
  always_comb begin
    pix_idx        = pixels_reg[3:0];
    pixels_shifted = pixels_reg >> 4;
    case (bpp)
      BPP_1: begin
        pix_idx        = {3'b000, pixels_reg[0]};
        pixels_shifted = pixels_reg >> 1;
      end
      BPP_2: begin
        pix_idx        = {2'b00, pixels_reg[1:0]};
        pixels_shifted = pixels_reg >> 2;
      end
      default: ;
    endcase
  end

  // palette lookup, widened/narrowed to the 8-bit output byte
  always_comb begin
    entry_sel             = palette_reg[int'(pix_idx)*ENTRY_W +: ENTRY_W];
    entry_byte            = '0;
    entry_byte[EB-1:0]    = entry_sel[EB-1:0];
  end

  // counter pacing, set loads from the FIFO and the sticky underrun flag
  always_comb begin
    cnt_next      = cnt_reg;
    set_next      = set_reg;
    pixels_next   = pixels_reg;
    palette_next  = palette_reg;
    underrun_next = underrun_reg;
    active_next   = active_reg;
    fifo_pop      = 1'b0;
    if (cfg_we && cfg_data[VID_UR_CLR_BIT]) underrun_next = 1'b0;
    if (mode == MODE_OFF) begin
      cnt_next    = 8'd1;
      set_next    = 12'd1;
      active_next = 1'b0;
    end else if (set_reg == 12'd1) begin
      set_next = scl_reg[SCL_CPS_LSB +: 12];
      cnt_next = scl_reg[SCL_CPP_LSB +: 8];
      if (!fifo_empty) begin
        fifo_pop     = 1'b1;
        pixels_next  = fifo_dout[31:0];
        palette_next = fifo_dout[SET_WIDTH-1:32];
        active_next  = 1'b1;
      end else begin
        // starved: keep the old set running and flag it
        pixels_next   = pixels_shifted;
        underrun_next = 1'b1;
        active_next   = 1'b0;
      end
    end else if (cnt_reg == 8'd1) begin
      cnt_next    = scl_reg[SCL_CPP_LSB +: 8];
      set_next    = set_reg - 12'd1;
      pixels_next = pixels_shifted;
    end else begin
      cnt_next = cnt_reg - 8'd1;
      set_next = set_reg - 12'd1;
    end
  end

  // main state registers
  always_ff @(posedge clk_vid or posedge res) begin
    if (res) begin
      vid_reg      <= '0;
      scl_reg      <= '0;
      cnt_reg      <= 8'd1;
      set_reg      <= 12'd1;
      pixels_reg   <= '0;
      palette_reg  <= '0;
      discrete_reg <= '0;
      underrun_reg <= 1'b0;
      active_reg   <= 1'b0;
    end else begin
      if (cfg_we) vid_reg <= cfg_data;
      if (scl_we) scl_reg <= scl_data;
      cnt_reg      <= cnt_next;
      set_reg      <= set_next;
      pixels_reg   <= pixels_next;
      palette_reg  <= palette_next;
      discrete_reg <= entry_byte;
      underrun_reg <= underrun_next;
      active_reg   <= active_next;
    end
  end

`ifdef COG_VIDX_COMPOSITE_EN
  logic [3:0] phase_reg;
  logic [3:0] baseband_reg;
  logic [3:0] broadcast_reg;
  logic [3:0] composite;
  logic [2:0] level;
  logic       aural_bit;

  assign composite = chroma_mod(discrete_reg, phase_reg, vid_reg[VID_BC_CHROMA_BIT]);
  assign level     = BC_LEVEL_TABLE[int'({carrier, composite[2:0]})*3 +: 3];
  assign aural_bit = carrier ^ aural[vid_reg[VID_AURAL_LSB +: 3]];

  // phase counter and the discrete -> baseband/broadcast pipeline stage
  always_ff @(posedge clk_vid or posedge res) begin
    if (res) begin
      phase_reg     <= '0;
      baseband_reg  <= '0;
      broadcast_reg <= '0;
    end else begin
      if (mode != MODE_OFF) phase_reg <= phase_reg + 4'd1;
      baseband_reg  <= chroma_mod(discrete_reg, phase_reg, vid_reg[VID_BB_CHROMA_BIT]);
      broadcast_reg <= {aural_bit, level};
    end
  end

  assign unused_bits = ^{vid_reg[VID_UR_CLR_BIT], vid_reg[21:13], vid_reg[12:8]};

  // output byte selection by mode, then pin mask
  always_comb begin
    out_byte = 8'h00;
    case (mode)
      MODE_OFF:  out_byte = 8'h00;
      MODE_DISC: out_byte = discrete_reg;
      MODE_BB:   out_byte = {broadcast_reg, baseband_reg};
      MODE_BC:   out_byte = {baseband_reg, broadcast_reg};
      default:   out_byte = 8'h00;
    endcase
    out_byte = out_byte & vid_reg[VID_MASK_LSB +: 8];
  end
`else
  assign unused_bits = ^{vid_reg[VID_UR_CLR_BIT], vid_reg[26:13], vid_reg[12:8],
                         aural, carrier};

  // output byte selection by mode, then pin mask
  always_comb begin
    out_byte = 8'h00;
    if (mode != MODE_OFF) out_byte = discrete_reg;
    out_byte = out_byte & vid_reg[VID_MASK_LSB +: 8];
  end
`endif

  generate
    if (GW == 0) begin : g_grp_fixed
      assign grp = 5'd0;
    end else begin : g_grp_sel
      assign grp = 5'(vid_reg[VID_GROUP_LSB +: GW]);
    end
  endgenerate

  // place the byte on the selected group; every other group stays low
  genvar gi;
  generate
    for (gi = 0; gi < GROUPS; gi++) begin : g_group
      assign pin_out[8*gi +: 8] = (grp == 5'(gi)) ? out_byte : 8'h00;
    end
  endgenerate

endmodule

// File: tb/tb_cog_vidx.sv
// tb_cog_vidx: scoreboard bench for cog_vidx. Stimulus pushes the expected
// per-clock pin_out stream into a queue; a monitor pops and compares once the
// DUT starts presenting output.
module tb_cog_vidx;

  localparam int PIN_W      = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int ENTRY_W    = 8;

  logic                   clk_vid = 1'b0;
  logic                   res = 1'b1;
  logic                   cfg_we = 1'b0;
  logic [31:0]            cfg_data = '0;
  logic                   scl_we = 1'b0;
  logic [19:0]            scl_data = '0;
  logic                   set_valid = 1'b0;
  logic                   set_ready;
  logic [31:0]            pixel = '0;
  logic [16*ENTRY_W-1:0]  color = '0;
  logic [7:0]             aural = '0;
  logic                   carrier = 1'b0;
  logic                   underrun;
  logic                   busy;
  logic [PIN_W-1:0]       pin_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [PIN_W-1:0] exp_q[$];
  logic             armed = 1'b0;

  cog_vidx #(
    .PIN_W      (PIN_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ENTRY_W    (ENTRY_W)
  ) dut (
    .clk_vid   (clk_vid),
    .res       (res),
    .cfg_we    (cfg_we),
    .cfg_data  (cfg_data),
    .scl_we    (scl_we),
    .scl_data  (scl_data),
    .set_valid (set_valid),
    .set_ready (set_ready),
    .pixel     (pixel),
    .color     (color),
    .aural     (aural),
    .carrier   (carrier),
    .underrun  (underrun),
    .busy      (busy),
    .pin_out   (pin_out)
  );

  always #5 clk_vid = ~clk_vid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // monitor: compares one expected pin_out word per clock once output starts
  always @(negedge clk_vid) begin
    if (exp_q.size() != 0 && (armed || pin_out != '0)) begin
      logic [PIN_W-1:0] e;
      armed = 1'b1;
      e = exp_q.pop_front();
      check("stream", 64'(pin_out), 64'(e));
      if (exp_q.size() == 0) armed = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk_vid);
    res = 1'b1;
    set_valid = 1'b0;
    cfg_we = 1'b0;
    scl_we = 1'b0;
    exp_q.delete();
    armed = 1'b0;
    repeat (2) @(negedge clk_vid);
    res = 1'b0;
  endtask

  task automatic write_cfg(input logic [31:0] d);
    @(negedge clk_vid);
    cfg_we = 1'b1;
    cfg_data = d;
    @(negedge clk_vid);
    cfg_we = 1'b0;
    $display("[TB] cfg write 0x%08h", d);
  endtask

  task automatic write_scl(input logic [7:0] cpp, input logic [11:0] cps);
    @(negedge clk_vid);
    scl_we = 1'b1;
    scl_data = {cpp, cps};
    @(negedge clk_vid);
    scl_we = 1'b0;
    $display("[TB] scale write cpp=%0d cps=%0d", cpp, cps);
  endtask

  task automatic push_set(input logic [31:0] px, input logic [16*ENTRY_W-1:0] col);
    int n;
    n = 0;
    @(negedge clk_vid);
    set_valid = 1'b1;
    pixel = px;
    color = col;
    while (!set_ready && n < 400) begin
      @(negedge clk_vid);
      n++;
    end
    if (!set_ready) begin
      check("push_timeout", 64'(set_ready), 64'd1);
    end else begin
      @(negedge clk_vid);
      $display("[TB] push set pixel=0x%08h entry0=0x%02h", px, col[7:0]);
    end
    set_valid = 1'b0;
  endtask

  task automatic expect_run(input logic [PIN_W-1:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_vid);
      n++;
    end
    check("stream_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    armed = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16*ENTRY_W-1:0] c;

    // reset state while res is held
    @(negedge clk_vid);
    check("reset_pin_out", 64'(pin_out), 64'd0);
    check("reset_set_ready", 64'(set_ready), 64'd0);
    check("reset_underrun", 64'(underrun), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    // 1bpp stream: pixel 0b101, e0=0x02 e1=0x07, 4 clocks per pixel
    do_reset();
    write_scl(8'd4, 12'd128);
    write_cfg(32'h2000_00FF);
    c = '0;
    c[7:0]  = 8'h02;
    c[15:8] = 8'h07;
    expect_run(32'h07, 4);
    expect_run(32'h02, 4);
    expect_run(32'h07, 4);
    expect_run(32'h02, 8);
    push_set(32'h0000_0005, c);
    wait_drain(400);

    // 4bpp stream on group 1 with mask 0x0F
    do_reset();
    write_scl(8'd3, 12'd64);
    write_cfg(32'h3000_010F);
    c = '0;
    c[15:8]    = 8'hA5;
    c[127:120] = 8'h3C;
    expect_run(32'h0000_0500, 3);
    expect_run(32'h0000_0C00, 3);
    expect_run(32'h0000_0000, 3);
    push_set(32'h0000_00F1, c);
    wait_drain(200);

    // asynchronous reset in the middle of that set
    check("busy_mid_set", 64'(busy), 64'd1);
    @(posedge clk_vid);
    #2 res = 1'b1;
    #1;
    check("res_pin_out", 64'(pin_out), 64'd0);
    check("res_set_ready", 64'(set_ready), 64'd0);
    check("res_busy", 64'(busy), 64'd0);
    @(negedge clk_vid);
    res = 1'b0;
    repeat (5) @(negedge clk_vid);
    check("off_pin_out", 64'(pin_out), 64'd0);
    check("off_set_ready", 64'(set_ready), 64'd0);
    write_cfg(32'h2000_00FF);
    check("on_set_ready", 64'(set_ready), 64'd1);
    check("on_pin_out", 64'(pin_out), 64'd0);

    // FIFO fill: 5 sets, FIFO_DEPTH 4, pops every 64 clocks
    do_reset();
    write_scl(8'd4, 12'd64);
    write_cfg(32'h2000_00FF);
    write_cfg(32'hA000_00FF);
    check("underrun_cleared", 64'(underrun), 64'd0);
    expect_run(32'h11, 64);
    expect_run(32'h22, 64);
    expect_run(32'h33, 64);
    expect_run(32'h44, 64);
    expect_run(32'h55, 72);
    for (int k = 1; k <= 4; k++) begin
      c = '0;
      c[7:0] = 8'(k * 8'h11);
      push_set(32'h0, c);
    end
    check("full_set_ready", 64'(set_ready), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    c = '0;
    c[7:0] = 8'h55;
    push_set(32'h0, c);
    wait_drain(700);

    // starved set boundary: underrun sticks, old palette keeps driving
    check("starved_underrun", 64'(underrun), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    write_cfg(32'hA000_00FF);
    check("underrun_clear", 64'(underrun), 64'd0);
    check("old_palette_out", 64'(pin_out), 64'h55);

`ifdef COG_VIDX_COMPOSITE_EN
    // baseband: discrete 0x8B with chroma on, MSB follows phase + 8
    begin
      logic prev;
      int   t;
      do_reset();
      write_scl(8'd4, 12'd64);
      write_cfg(32'h4400_00FF);
      c = '0;
      c[7:0] = 8'h8B;
      push_set(32'h0, c);
      prev = pin_out[3];
      t = 0;
      while (pin_out[3] == prev && t < 200) begin
        @(negedge clk_vid);
        t++;
      end
      for (int k = 0; k < 3; k++) begin
        prev = pin_out[3];
        t = 0;
        while (pin_out[3] == prev && t < 40) begin
          @(negedge clk_vid);
          t++;
        end
        check("bb_msb_period", 64'(t), 64'd8);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
